queue_perf_monitor: RTL and testbench
=====================================

QUEUE_PERF_MONITOR -- requirements
Module: queue_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of monitored queues.
REQ-002 SHALL have parameter DEPTH, default 16: capacity of each monitored queue, in entries.
REQ-003 SHALL have parameter CNT_W, default 32: width of every event counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port q_flush, input, NUM_CH: per-channel queue reset/flush.
REQ-007 SHALL have port q_enq, input, NUM_CH: per-channel enqueue strobe.
REQ-008 SHALL have port q_deq, input, NUM_CH: per-channel dequeue strobe.
REQ-009 SHALL have port q_full, input, NUM_CH: per-channel full flag from the queue.
REQ-010 SHALL have port q_empty, input, NUM_CH: per-channel empty flag from the queue.
REQ-011 SHALL have port cmd_start, input, 1: go to RUN.
REQ-012 SHALL have port cmd_stop, input, 1: go to HALT.
REQ-013 SHALL have port cmd_clear, input, 1: zero all counters and shadow state.
REQ-014 SHALL have port rd_req, input, 1: counter read request.
REQ-015 SHALL have port rd_ch, input, $clog2(NUM_CH): channel to read.
REQ-016 SHALL have port rd_sel, input, 3: counter select (0 enq, 1 deq, 2 full_cyc, 3 empty_cyc, 4 ovf, 5 unf, 6 flush, 7 max_occ).
REQ-017 SHALL have port rd_valid, output, 1: rd_data is valid.
REQ-018 SHALL have port rd_data, output, CNT_W: selected counter value.
REQ-019 SHALL have port mismatch, output, NUM_CH: sticky shadow/flag disagreement per channel.
REQ-020 SHALL have port state, output, 2: current state (0 IDLE, 1 RUN, 2 HALT).

Function
REQ-021 SHALL implement FSM IDLE->RUN on cmd_start, RUN->HALT on cmd_stop, HALT->RUN on cmd_start; cmd_clear from any state returns to IDLE.
REQ-022 SHALL give priority cmd_clear > cmd_stop > cmd_start when asserted in the same cycle.
REQ-023 SHALL update counters only in RUN; counters hold in IDLE and HALT.
REQ-024 SHALL update the shadow occupancy occ[c] (width $clog2(DEPTH+1)) in all states except during the cycle cmd_clear is asserted: flush -> 0; otherwise +1 on accepted enq only, -1 on accepted deq only, unchanged on both or neither.
REQ-025 SHALL treat an enq as accepted only when q_full=0, and a deq as accepted only when q_empty=0.
REQ-026 SHALL increment enq/deq counters on accepted events, and ovf on enq with q_full=1, unf on deq with q_empty=1.
REQ-027 SHALL increment full_cyc/empty_cyc each RUN cycle in which q_full/q_empty is 1, and flush once per cycle with q_flush=1.
REQ-028 SHALL, when q_flush=1, ignore that cycle's enq/deq for occ, enq, deq, ovf and unf; full_cyc, empty_cyc and flush still count.
REQ-029 SHALL saturate every counter at 2^CNT_W-1 with no wrap.
REQ-030 SHALL keep max_occ[c] = maximum post-update occ[c] seen in RUN, zero-extended to CNT_W on read.
REQ-031 SHALL set mismatch[c], sticky until reset or cmd_clear, when registered occ[c]==0 XOR q_empty[c], or occ[c]==DEPTH XOR q_full[c]; never in the flush cycle.
REQ-032 SHALL return a read 1 cycle after rd_req with rd_valid=1 for exactly that cycle; back-to-back requests give one result per cycle.
REQ-033 SHALL return the counter value as it stands before same-cycle updates (registered read).
REQ-034 SHALL return 0 for rd_ch >= NUM_CH.
REQ-035 SHALL take effect of cmd_clear in the next cycle: all counters, occ, max_occ and mismatch read 0.

Reset
REQ-036 SHALL, on rst=0 and asynchronously, force state=IDLE, all counters, occ, max_occ, mismatch, rd_valid and rd_data to 0.
REQ-037 SHALL, on reset mid-RUN, discard all counts, and on rst release remain in IDLE until cmd_start.

Verification
REQ-038 SHALL be verified thus: start, ch0 3 enq then 1 deq, read sel0/1/7 -> 3, 1, 3.
REQ-039 SHALL be verified thus: start, ch1 q_full=1 with enq for 5 cycles -> ovf=5, full_cyc=5, enq=0.
REQ-040 SHALL be verified thus: CNT_W=4, 20 accepted enq -> enq reads 15.
REQ-041 SHALL be verified thus: stop then 4 enq, read enq -> unchanged; occ is advanced, mismatch stays 0 with a consistent queue model.
REQ-042 SHALL be verified thus: q_empty forced 0 while occ=0 -> mismatch[c]=1 next cycle; cmd_clear -> 0.
REQ-043 SHALL be verified thus: rst low mid-RUN with enq=7 -> state=0, enq reads 0 after release.

Source files
------------

// File: rtl/queue_perf_monitor.sv
// Queue performance monitor: per-channel saturating event counters, a
// shadow occupancy model with sticky flag-mismatch detection, and a
// registered counter read port.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   q_flush/q_enq/q_deq   per-channel queue activity strobes
//   q_full/q_empty        per-channel flags reported by the queue
//   cmd_start/stop/clear  run control (clear > stop > start)
//   rd_req/rd_ch/rd_sel   counter read request, channel, select
//   rd_valid/rd_data      read result, one cycle after rd_req
//   mismatch              sticky shadow-vs-flag disagreement
//   state                 0 IDLE, 1 RUN, 2 HALT
module queue_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] q_flush,
    input  logic [NUM_CH-1:0] q_enq,
    input  logic [NUM_CH-1:0] q_deq,
    input  logic [NUM_CH-1:0] q_full,
    input  logic [NUM_CH-1:0] q_empty,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_clear,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] mismatch,
    output logic [1:0]        state
);

    localparam int N_EV     = 7;
    localparam int EV_ENQ   = 0;
    localparam int EV_DEQ   = 1;
    localparam int EV_FULL  = 2;
    localparam int EV_EMPTY = 3;
    localparam int EV_OVF   = 4;
    localparam int EV_UNF   = 5;
    localparam int EV_FLUSH = 6;

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            st;
    logic [CNT_W-1:0]  cnt     [NUM_CH][N_EV];
    logic [OCC_W-1:0]  occ     [NUM_CH];
    logic [OCC_W-1:0]  occ_nxt [NUM_CH];
    logic [OCC_W-1:0]  max_occ [NUM_CH];
    logic [N_EV-1:0]   ev      [NUM_CH];
    logic [NUM_CH-1:0] enq_ok;
    logic [NUM_CH-1:0] deq_ok;
    logic [NUM_CH-1:0] mis_ev;
    logic [CNT_W-1:0]  rd_mux;

    assign state = st;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A flush cycle discards that cycle's enq/deq entirely.
    always_comb begin
        enq_ok = '0;
        deq_ok = '0;
        mis_ev = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            enq_ok[c] = q_enq[c] & ~q_full[c] & ~q_flush[c];
            deq_ok[c] = q_deq[c] & ~q_empty[c] & ~q_flush[c];

            ev[c]           = '0;
            ev[c][EV_ENQ]   = enq_ok[c];
            ev[c][EV_DEQ]   = deq_ok[c];
            ev[c][EV_FULL]  = q_full[c];
            ev[c][EV_EMPTY] = q_empty[c];
            ev[c][EV_OVF]   = q_enq[c] & q_full[c] & ~q_flush[c];
            ev[c][EV_UNF]   = q_deq[c] & q_empty[c] & ~q_flush[c];
            ev[c][EV_FLUSH] = q_flush[c];

            // Bounds clamp keeps the shadow in range even when the
            // queue's flags lie; mismatch reports that case.
            occ_nxt[c] = occ[c];
            if (q_flush[c]) begin
                occ_nxt[c] = '0;
            end else if (enq_ok[c] && !deq_ok[c] && occ[c] != OCC_MAX) begin
                occ_nxt[c] = occ[c] + OCC_W'(1);
            end else if (deq_ok[c] && !enq_ok[c] && occ[c] != '0) begin
                occ_nxt[c] = occ[c] - OCC_W'(1);
            end

            mis_ev[c] = ~q_flush[c] &
                        (((occ[c] == '0) ^ q_empty[c]) |
                         ((occ[c] == OCC_MAX) ^ q_full[c]));
        end
    end

    // Channel codes with no matching channel fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                if (rd_sel == 3'd7) begin
                    rd_mux = CNT_W'(max_occ[c]);
                end else begin
                    rd_mux = cnt[c][rd_sel];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            mismatch <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                occ[c]     <= '0;
                max_occ[c] <= '0;
                for (int k = 0; k < N_EV; k++) begin
                    cnt[c][k] <= '0;
                end
            end
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end

            if (cmd_clear) begin
                st       <= IDLE;
                mismatch <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    occ[c]     <= '0;
                    max_occ[c] <= '0;
                    for (int k = 0; k < N_EV; k++) begin
                        cnt[c][k] <= '0;
                    end
                end
            end else begin
                if (cmd_stop) begin
                    if (st == RUN) begin
                        st <= HALT;
                    end
                end else if (cmd_start && st != RUN) begin
                    st <= RUN;
                end

                for (int c = 0; c < NUM_CH; c++) begin
                    occ[c] <= occ_nxt[c];
                    if (mis_ev[c]) begin
                        mismatch[c] <= 1'b1;
                    end
                    if (st == RUN) begin
                        for (int k = 0; k < N_EV; k++) begin
                            if (ev[c][k]) begin
                                cnt[c][k] <= sat_inc(cnt[c][k]);
                            end
                        end
                        if (occ_nxt[c] > max_occ[c]) begin
                            max_occ[c] <= occ_nxt[c];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_queue_perf_monitor.sv
// Directed bench for queue_perf_monitor: a default instance plus a
// 3-channel, 4-bit-counter instance for saturation and range checks.
module tb_queue_perf_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  q_flush = '0;
    logic [3:0]  q_enq = '0;
    logic [3:0]  q_deq = '0;
    logic [3:0]  q_full = '0;
    logic [3:0]  q_empty = '1;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_ch = '0;
    logic [2:0]  rd_sel = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  mismatch;
    logic [1:0]  state;
    logic        s_rd_valid;
    logic [3:0]  s_rd_data;
    logic [2:0]  s_mismatch;
    logic [1:0]  s_state;

    int         checks = 0;
    int         failures = 0;
    int         m_occ [4] = '{0, 0, 0, 0};
    logic [3:0] frc_full = '0;
    logic [3:0] frc_ne = '0;

    always #5 clk = ~clk;

    queue_perf_monitor u_dut (
        .clk(clk), .rst(rst),
        .q_flush(q_flush), .q_enq(q_enq), .q_deq(q_deq),
        .q_full(q_full), .q_empty(q_empty),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear(cmd_clear),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mismatch(mismatch), .state(state)
    );

    queue_perf_monitor #(.NUM_CH(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .q_flush(q_flush[2:0]), .q_enq(q_enq[2:0]),
        .q_deq(q_deq[2:0]),
        .q_full(q_full[2:0]), .q_empty(q_empty[2:0]),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear(cmd_clear),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .mismatch(s_mismatch), .state(s_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags follow the bench's own queue model unless forced.
    task automatic refresh();
        for (int c = 0; c < 4; c++) begin
            q_full[c]  = frc_full[c] | (m_occ[c] == 16);
            q_empty[c] = ~frc_ne[c] & (m_occ[c] == 0);
        end
    endtask

    task automatic cyc(input logic [3:0] e, input logic [3:0] d,
                       input logic [3:0] f);
        logic ea;
        logic da;
        refresh();
        q_enq = e;
        q_deq = d;
        q_flush = f;
        tick();
        for (int c = 0; c < 4; c++) begin
            ea = e[c] & ~q_full[c];
            da = d[c] & ~q_empty[c];
            if (f[c]) m_occ[c] = 0;
            else if (ea && !da) m_occ[c] = m_occ[c] + 1;
            else if (da && !ea) m_occ[c] = m_occ[c] - 1;
        end
        q_enq = '0;
        q_deq = '0;
        q_flush = '0;
        refresh();
    endtask

    task automatic cmd(input logic s, input logic p, input logic c);
        cmd_start = s;
        cmd_stop = p;
        cmd_clear = c;
        tick();
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        cmd_clear = 1'b0;
        if (c) m_occ = '{0, 0, 0, 0};
        refresh();
    endtask

    task automatic rd(input logic [1:0] ch, input logic [2:0] sel);
        rd_req = 1'b1;
        rd_ch = ch;
        rd_sel = sel;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        refresh();
        repeat (3) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        rst = 1'b1;
        tick();

        rd(0, 0);
        chk("idle_rd_valid", 32'(rd_valid), 1);
        chk("idle_rd_data", rd_data, 0);
        tick();
        chk("rd_valid_drop", 32'(rd_valid), 0);

        cmd(1, 1, 0);
        chk("idle_stop_wins", 32'(state), 0);
        cmd(1, 0, 0);
        chk("start_run", 32'(state), 1);

        repeat (3) cyc(4'b0001, 4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0001, 4'b0000);
        rd(0, 0);
        chk("ch0_enq", rd_data, 3);
        rd(0, 1);
        chk("ch0_deq", rd_data, 1);
        rd(0, 7);
        chk("ch0_max_occ", rd_data, 3);
        rd(0, 3);
        chk("ch0_empty_cyc", rd_data, 1);

        rd_req = 1'b1;
        rd_ch = 2'd0;
        rd_sel = 3'd0;
        tick();
        chk("b2b_1_data", rd_data, 3);
        chk("b2b_1_valid", 32'(rd_valid), 1);
        rd_sel = 3'd1;
        tick();
        rd_req = 1'b0;
        chk("b2b_2_data", rd_data, 1);
        chk("b2b_2_valid", 32'(rd_valid), 1);
        tick();
        chk("b2b_end_valid", 32'(rd_valid), 0);

        frc_full = 4'b0010;
        repeat (5) cyc(4'b0010, 4'b0000, 4'b0000);
        frc_full = '0;
        refresh();
        chk("ch1_mismatch", 32'(mismatch), 32'b0010);
        rd(1, 4);
        chk("ch1_ovf", rd_data, 5);
        rd(1, 2);
        chk("ch1_full_cyc", rd_data, 5);
        rd(1, 0);
        chk("ch1_enq", rd_data, 0);

        cmd(1, 1, 0);
        chk("run_stop_wins", 32'(state), 2);
        repeat (4) cyc(4'b0001, 4'b0000, 4'b0000);
        rd(0, 0);
        chk("halt_enq_hold", rd_data, 3);
        chk("halt_mismatch", 32'(mismatch), 32'b0010);
        cmd(1, 0, 0);
        chk("halt_to_run", 32'(state), 1);
        cyc(4'b0001, 4'b0000, 4'b0000);
        rd(0, 7);
        chk("occ_adv_max", rd_data, 7);
        rd(0, 0);
        chk("run_enq_again", rd_data, 4);

        frc_ne = 4'b0100;
        cyc(4'b0000, 4'b0000, 4'b0000);
        frc_ne = '0;
        refresh();
        chk("ch2_mismatch", 32'(mismatch), 32'b0110);
        frc_ne = 4'b1000;
        cyc(4'b0000, 4'b0000, 4'b1000);
        frc_ne = '0;
        refresh();
        chk("flush_no_mismatch", 32'(mismatch), 32'b0110);
        rd(3, 6);
        chk("ch3_flush", rd_data, 1);

        cmd(0, 1, 0);
        cmd(1, 0, 1);
        chk("clear_wins", 32'(state), 0);
        chk("clear_mismatch", 32'(mismatch), 0);
        rd(1, 4);
        chk("clear_ovf", rd_data, 0);
        rd(0, 7);
        chk("clear_max", rd_data, 0);
        rd(0, 0);
        chk("clear_enq", rd_data, 0);

        cmd(1, 0, 0);
        cyc(4'b0001, 4'b0000, 4'b0000);
        repeat (19) cyc(4'b0001, 4'b0001, 4'b0000);
        rd(0, 0);
        chk("enq_20", rd_data, 20);
        chk("sat_enq", 32'(s_rd_data), 15);
        chk("sat_valid", 32'(s_rd_valid), 1);
        rd(0, 1);
        chk("deq_19", rd_data, 19);
        chk("sat_deq", 32'(s_rd_data), 15);
        chk("sat_mismatch", 32'(s_mismatch), 0);

        cyc(4'b0000, 4'b0000, 4'b1000);
        rd(3, 6);
        chk("ch3_flush_4ch", rd_data, 1);
        chk("sat_ch_range", 32'(s_rd_data), 0);

        cmd(0, 0, 1);
        cmd(1, 0, 0);
        repeat (7) cyc(4'b0010, 4'b0000, 4'b0000);
        rd(1, 0);
        chk("pre_rst_enq", rd_data, 7);
        chk("pre_rst_state", 32'(state), 1);
        rst = 1'b0;
        m_occ = '{0, 0, 0, 0};
        refresh();
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_data", rd_data, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 0);
        rd(1, 0);
        chk("post_rst_enq", rd_data, 0);
        cyc(4'b0010, 4'b0000, 4'b0000);
        rd(1, 0);
        chk("idle_enq_hold", rd_data, 0);
        chk("idle_stays", 32'(state), 0);
        chk("post_rst_mismatch", 32'(mismatch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
